// File: rtl/alu_issue_arbiter_if.sv
// Bundle of request, ALU and response signals for alu_issue_arbiter.
// The arbiter connects through the slave modport and its environment through the master modport.
interface alu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*4-1:0]      req_func;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;

  logic                      alu_en;
  logic [3:0]                alu_func;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_out;
  logic                      alu_cmp_lt;
  logic                      alu_cmp_eq;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_out;
  logic                      resp_lt;
  logic                      resp_eq;
  logic                      resp_err;
  logic                      busy;

  modport slave (
    input  req_valid, req_func, req_a, req_b,
    input  alu_out, alu_cmp_lt, alu_cmp_eq,
    input  resp_ready,
    output req_ready,
    output alu_en, alu_func, alu_a, alu_b,
    output resp_valid, resp_id, resp_out, resp_lt, resp_eq, resp_err,
    output busy
  );

  modport master (
    output req_valid, req_func, req_a, req_b,
    output alu_out, alu_cmp_lt, alu_cmp_eq,
    output resp_ready,
    input  req_ready,
    input  alu_en, alu_func, alu_a, alu_b,
    input  resp_valid, resp_id, resp_out, resp_lt, resp_eq, resp_err,
    input  busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of requester ops onto one shared scalar ALU. Each result is returned on a tagged response channel.
// Divide-by-zero and illegal function codes are answered locally without touching the ALU.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  alu_issue_arbiter_if.slave bus_if
);
  localparam int unsigned     FUNC_W = 4;
  localparam logic [FUNC_W-1:0] F_DIV = 4'd3;
  localparam logic [FUNC_W-1:0] F_CMP = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic                busy_q;
  logic                alu_en_q;
  logic [FUNC_W-1:0]   alu_func_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic                resp_valid_q;
  logic [ID_W-1:0]     resp_id_q;
  logic [DATA_W-1:0]   resp_out_q;
  logic                resp_lt_q;
  logic                resp_eq_q;
  logic                resp_err_q;

  logic [NUM_REQ-1:0]  rot_c;
  logic [NUM_REQ-1:0]  scan_c;
  logic                win_vld_c;
  logic [ID_W-1:0]     win_id_c;
  logic [FUNC_W-1:0]   sel_func_c;
  logic [DATA_W-1:0]   sel_a_c;
  logic [DATA_W-1:0]   sel_b_c;
  logic                legal_c;
  logic                div0_c;
  logic                trap_c;

  // Rotate the valid vector so that the pointer is at bit 0, then take the first set bit.
  always_comb begin
    rot_c     = NUM_REQ'({bus_if.req_valid, bus_if.req_valid} >> ptr_q);
    scan_c    = '0;
    win_vld_c = 1'b0;
    win_id_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_c = rot_c >> k;
      if (!win_vld_c && scan_c[0]) begin
        win_vld_c = 1'b1;
        win_id_c  = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_func_c = '0;
    sel_a_c    = '0;
    sel_b_c    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win_id_c) begin
        sel_func_c = FUNC_W'(bus_if.req_func >> (FUNC_W * j));
        sel_a_c    = DATA_W'(bus_if.req_a >> (DATA_W * j));
        sel_b_c    = DATA_W'(bus_if.req_b >> (DATA_W * j));
      end
    end
  end

  always_comb begin
    legal_c = 1'b0;
    case (sel_func_c)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15: legal_c = 1'b1;
      default:                                               legal_c = 1'b0;
    endcase
    div0_c = (sel_func_c == F_DIV) && (sel_b_c == '0);
    trap_c = !legal_c || div0_c;
  end

  assign bus_if.req_ready = (state_q == S_IDLE && win_vld_c) ? (NUM_REQ'(1) << win_id_c) : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_func_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_out_q   <= '0;
      resp_lt_q    <= 1'b0;
      resp_eq_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld_c) begin
            ptr_q     <= (win_id_c == ID_W'(NUM_REQ - 1)) ? '0 : win_id_c + 1'b1;
            resp_id_q <= win_id_c;
            busy_q    <= 1'b1;
            if (trap_c) begin
              // Answer straight away; the ALU never sees a trapped op.
              resp_valid_q <= 1'b1;
              resp_out_q   <= div0_c ? '1 : '0;
              resp_err_q   <= 1'b1;
              resp_lt_q    <= 1'b0;
              resp_eq_q    <= 1'b0;
              state_q      <= S_RESP;
            end else begin
              alu_en_q   <= 1'b1;
              alu_func_q <= sel_func_c;
              alu_a_q    <= sel_a_c;
              alu_b_q    <= sel_b_c;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          alu_en_q <= 1'b0;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // The ALU output is registered, so the result is ready one cycle after the enable.
          resp_out_q   <= bus_if.alu_out;
          resp_lt_q    <= (alu_func_q == F_CMP) && bus_if.alu_cmp_lt;
          resp_eq_q    <= (alu_func_q == F_CMP) && bus_if.alu_cmp_eq;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus_if.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.alu_en     = alu_en_q;
  assign bus_if.alu_func   = alu_func_q;
  assign bus_if.alu_a      = alu_a_q;
  assign bus_if.alu_b      = alu_b_q;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_id    = resp_id_q;
  assign bus_if.resp_out   = resp_out_q;
  assign bus_if.resp_lt    = resp_lt_q;
  assign bus_if.resp_eq    = resp_eq_q;
  assign bus_if.resp_err   = resp_err_q;
  assign bus_if.busy       = busy_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: a registered ALU stub, directed ops, and a random
// phase checked cycle by cycle against a transaction-level reference model.
module tb_alu_issue_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FW      = NUM_REQ * 4;
  localparam int unsigned AW      = NUM_REQ * DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   ptr_m   = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();
  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus_if (bus)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return p[15:0];
      4'd3:    return (b == 16'd0) ? 16'hFFFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a >> b[3:0];
      4'd15:   return a << b[3:0];
      4'd8:    return a - b;
      default: return 16'h0;
    endcase
  endfunction

  // Registered ALU: flags follow the operands for every op, the arbiter must mask them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_out    <= 16'h0;
      bus.alu_cmp_lt <= 1'b0;
      bus.alu_cmp_eq <= 1'b0;
    end else if (bus.alu_en) begin
      bus.alu_out    <= alu_fn(bus.alu_func, bus.alu_a, bus.alu_b);
      bus.alu_cmp_lt <= $signed(bus.alu_a) < $signed(bus.alu_b);
      bus.alu_cmp_eq <= bus.alu_a == bus.alu_b;
    end
  end

  task automatic ref_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] out, output logic lt, output logic eq, output logic err);
    logic legal;
    legal = f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15};
    err   = !legal || (f == 4'd3 && b == 16'd0);
    out   = !legal ? 16'h0 : alu_fn(f, a, b);
    lt    = !err && f == 4'd8 && ($signed(a) < $signed(b));
    eq    = !err && f == 4'd8 && (a == b);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slot(input int id, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    bus.req_func  = (bus.req_func & ~(FW'(4'hF) << (4 * id))) | (FW'(f) << (4 * id));
    bus.req_a     = (bus.req_a & ~(AW'(16'hFFFF) << (DATA_W * id))) | (AW'(a) << (DATA_W * id));
    bus.req_b     = (bus.req_b & ~(AW'(16'hFFFF) << (DATA_W * id))) | (AW'(b) << (DATA_W * id));
    bus.req_valid = bus.req_valid | (NUM_REQ'(1) << id);
  endtask

  // One op from a single requester; hold > 0 stalls the response channel that many cycles.
  task automatic run_op(input int id, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] eo;
    logic elt, eeq, eerr;
    int lat, n_en, exp_lat, other;
    ref_op(f, a, b, eo, elt, eeq, eerr);
    exp_lat = eerr ? 1 : 3;
    lat = 0;
    n_en = 0;
    bus.resp_ready = (hold == 0);
    bus.req_valid  = '0;
    set_slot(id, f, a, b);
    #1;
    chk("grant_onehot", 32'(bus.req_ready), 32'(1) << id);
    chk("grant_busy", 32'(bus.busy), 0);
    nxt();
    bus.req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      if (bus.alu_en) begin
        n_en++;
        chk("alu_func", 32'(bus.alu_func), 32'(f));
        chk("alu_a", 32'(bus.alu_a), 32'(a));
        chk("alu_b", 32'(bus.alu_b), 32'(b));
      end
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
      nxt();
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("alu_en_pulses", 32'(n_en), eerr ? 0 : 1);
    chk("resp_id", 32'(bus.resp_id), 32'(id));
    chk("resp_out", 32'(bus.resp_out), 32'(eo));
    chk("resp_lt", 32'(bus.resp_lt), 32'(elt));
    chk("resp_eq", 32'(bus.resp_eq), 32'(eeq));
    chk("resp_err", 32'(bus.resp_err), 32'(eerr));
    if (hold > 0) begin
      other = (id + 1) % NUM_REQ;
      set_slot(other, 4'd0, 16'd1, 16'd1);
      #1;
      for (int h = 0; h < hold; h++) begin
        chk("hold_ready", 32'(bus.req_ready), 0);
        chk("hold_valid", 32'(bus.resp_valid), 1);
        chk("hold_out", 32'(bus.resp_out), 32'(eo));
        chk("hold_busy", 32'(bus.busy), 1);
        nxt();
      end
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
    end
    nxt();
    chk("post_resp_valid", 32'(bus.resp_valid), 0);
    chk("post_busy", 32'(bus.busy), 0);
    bus.resp_ready = 1'b0;
    ptr_m = (id + 1) % NUM_REQ;
  endtask

  task automatic reset_test();
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    set_slot(3, 4'd2, 16'd5, 16'd6);
    #1;
    chk("rst_grant", 32'(bus.req_ready), 32'h8);
    nxt();
    bus.req_valid = '0;
    nxt();
    chk("rst_pre_busy", 32'(bus.busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_alu_en", 32'(bus.alu_en), 0);
    chk("rst_alu_func", 32'(bus.alu_func), 0);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_alu_b", 32'(bus.alu_b), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_out", 32'(bus.resp_out), 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_resp", 32'(bus.resp_valid), 0);
      nxt();
    end
    bus.resp_ready = 1'b0;
    ptr_m = 0;
  endtask

  task automatic rr_test();
    int pend[$];
    int g, last, pid;
    g = 0;
    last = 0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 4'd0, 16'(i * 16 + 1), 16'(i));
    #1;
    for (int cyc = 0; cyc < 40 && g < 5; cyc++) begin
      if (bus.resp_valid) begin
        pid = (pend.size() > 0) ? pend.pop_front() : -1;
        chk("rr_resp_id", 32'(bus.resp_id), 32'(pid));
        chk("rr_resp_out", 32'(bus.resp_out), 32'(pid * 17 + 1));
      end
      if (bus.req_ready != '0) begin
        chk("rr_grant", 32'(bus.req_ready), 32'(1) << ptr_m);
        if (g > 0) chk("rr_gap", 32'(cyc - last), 4);
        last = cyc;
        pend.push_back(ptr_m);
        ptr_m = (ptr_m + 1) % NUM_REQ;
        g++;
      end
      @(posedge clk);
      #1;
    end
    chk("rr_grant_count", 32'(g), 5);
    bus.req_valid = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.resp_valid) begin
        pid = (pend.size() > 0) ? pend.pop_front() : -1;
        chk("rr_drain_id", 32'(bus.resp_id), 32'(pid));
        chk("rr_drain_out", 32'(bus.resp_out), 32'(pid * 17 + 1));
      end
      @(posedge clk);
      #1;
    end
    chk("rr_all_answered", 32'(pend.size()), 0);
    bus.resp_ready = 1'b0;
    nxt();
  endtask

  // Random requests; the model tracks pointer, outstanding op and expected timing per cycle.
  task automatic rand_test(input int ncyc);
    bit          mv [NUM_REQ];
    logic [3:0]  mf [NUM_REQ];
    logic [15:0] ma [NUM_REQ];
    logic [15:0] mb [NUM_REQ];
    logic [FW-1:0] fv;
    logic [AW-1:0] av, bv;
    logic [NUM_REQ-1:0] vv;
    logic [31:0] exp_rdy;
    logic [15:0] eo, ea, eb;
    logic [3:0]  ef;
    logic elt, eeq, eerr;
    bit outst, exp_rv, exp_en;
    int w, idx, g_cyc, e_lat, e_id, drop_id, n_resp;
    outst = 0; drop_id = -1; n_resp = 0; g_cyc = 0; e_lat = 3; e_id = 0;
    eo = '0; ea = '0; eb = '0; ef = '0; elt = 0; eeq = 0; eerr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mv[i] = 0; mf[i] = '0; ma[i] = '0; mb[i] = '0;
    end
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (drop_id >= 0) mv[drop_id] = 0;
      drop_id = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!mv[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1;
          mf[i] = 4'($urandom_range(0, 15));
          ma[i] = 16'($urandom);
          mb[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        end
      end
      fv = '0; av = '0; bv = '0; vv = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        fv = fv | (FW'(mf[i]) << (4 * i));
        av = av | (AW'(ma[i]) << (DATA_W * i));
        bv = bv | (AW'(mb[i]) << (DATA_W * i));
        vv = vv | (NUM_REQ'(mv[i]) << i);
      end
      bus.req_func = fv; bus.req_a = av; bus.req_b = bv; bus.req_valid = vv;
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (!outst) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (ptr_m + k) % NUM_REQ;
          if (w < 0 && mv[idx]) w = idx;
        end
      end
      exp_rdy = (w < 0) ? 32'h0 : (32'(1) << w);
      chk("rnd_ready", 32'(bus.req_ready), exp_rdy);
      if (w >= 0) begin
        outst = 1; g_cyc = cyc; e_id = w; ef = mf[w]; ea = ma[w]; eb = mb[w];
        ref_op(ef, ea, eb, eo, elt, eeq, eerr);
        e_lat = eerr ? 1 : 3;
        ptr_m = (w + 1) % NUM_REQ;
        drop_id = w;
      end
      exp_rv = outst && cyc >= g_cyc + e_lat;
      chk("rnd_resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rnd_resp_id", 32'(bus.resp_id), 32'(e_id));
        chk("rnd_resp_out", 32'(bus.resp_out), 32'(eo));
        chk("rnd_resp_flags", {29'h0, bus.resp_err, bus.resp_lt, bus.resp_eq}, {29'h0, eerr, elt, eeq});
      end
      exp_en = outst && !eerr && cyc == g_cyc + 1;
      chk("rnd_alu_en", 32'(bus.alu_en), 32'(exp_en));
      if (exp_en) chk("rnd_alu_ops", {12'h0, bus.alu_func, bus.alu_a}, {12'h0, ef, ea});
      if (exp_en) chk("rnd_alu_b", 32'(bus.alu_b), 32'(eb));
      chk("rnd_busy", 32'(bus.busy), 32'(outst && cyc > g_cyc));
      if (exp_rv && bus.resp_ready) begin
        outst = 0;
        n_resp++;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_progress", 32'(n_resp > 20), 1);
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_func   = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_resp_valid", 32'(bus.resp_valid), 0);
    chk("reset_alu_en", 32'(bus.alu_en), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_resp_out", 32'(bus.resp_out), 0);
    chk("reset_alu_func", 32'(bus.alu_func), 0);
    nxt();

    run_op(2, 4'd0, 16'd7, 16'd5, 0);
    run_op(1, 4'd8, 16'hFFFE, 16'd3, 0);
    run_op(1, 4'd1, 16'd9, 16'd9, 0);
    run_op(0, 4'd3, 16'd100, 16'd0, 0);
    run_op(0, 4'd9, 16'd100, 16'd4, 0);
    run_op(2, 4'd15, 16'h0013, 16'd4, 0);
    run_op(3, 4'd2, 16'd300, 16'd3, 5);
    reset_test();
    rr_test();
    rand_test(600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
